// File: rtl/fp_pkg.sv
// Shared floating-point helpers: field extraction, class tests and the
// canonical quiet NaN, usable by any FPU datapath width up to 64 bits.
package fp_pkg;

  localparam int FP_EW_DEF = 8;
  localparam int FP_MW_DEF = 23;
  localparam int FP_MAX_W  = 64;

  typedef logic [FP_MAX_W-1:0] fp_word_t;

  typedef enum logic [1:0] {
    SPC_NONE = 2'd0,
    SPC_QNAN = 2'd1,
    SPC_INF  = 2'd2
  } spc_kind_e;

  // Width-agnostic helpers: operands are zero-extended into fp_word_t and
  // the caller truncates the result back to its own field width.
  function automatic fp_word_t fp_ones(input int n);
    return (fp_word_t'(1) << n) - fp_word_t'(1);
  endfunction

  function automatic logic fp_sign(input fp_word_t x, input int ew, input int mw);
    return x[ew+mw];
  endfunction

  function automatic fp_word_t fp_exp(input fp_word_t x, input int ew, input int mw);
    return (x >> mw) & fp_ones(ew);
  endfunction

  function automatic fp_word_t fp_man(input fp_word_t x, input int mw);
    return x & fp_ones(mw);
  endfunction

  function automatic logic fp_is_nan(input fp_word_t x, input int ew, input int mw);
    return (fp_exp(x, ew, mw) == fp_ones(ew)) && (fp_man(x, mw) != '0);
  endfunction

  function automatic logic fp_is_inf(input fp_word_t x, input int ew, input int mw);
    return (fp_exp(x, ew, mw) == fp_ones(ew)) && (fp_man(x, mw) == '0);
  endfunction

  // Denormals are flushed, so any zero exponent counts as zero.
  function automatic logic fp_is_zero(input fp_word_t x, input int ew, input int mw);
    return fp_exp(x, ew, mw) == '0;
  endfunction

  function automatic fp_word_t fp_qnan(input int ew, input int mw);
    return (fp_ones(ew) << mw) | (fp_word_t'(1) << (mw - 1));
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; cnt = N when din is all zeros.
module fp_lzc #(
  parameter int N  = 25,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  din,
  output logic [CW-1:0] cnt
);

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    cnt = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (din[i]) cnt = CW'(N - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage FP add/subtract (align / add+normalise / round+specials) with
// RNE rounding, flush-to-zero, a tag side-channel and global-stall backpressure.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EW    = FP_EW_DEF,
  parameter int MW    = FP_MW_DEF,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EW+MW:0]   x1,
  input  logic [EW+MW:0]   x2,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW+MW:0]   y,
  output logic [TAG_W-1:0] out_tag,
  output logic             ovf,
  output logic             unf
);

  localparam int W   = 1 + EW + MW;
  localparam int DW  = MW + 4;
  localparam int LZW = MW + 2;
  localparam int CW  = $clog2(LZW + 1);
  localparam int XW  = EW + 1;
  localparam int RW  = MW + 2;
  localparam logic [EW-1:0] EXP_ONES = '1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    spc_kind_e        spc;
    logic             spc_sign;
    logic             sign;
    logic             zero_sign;
    logic             eff_sub;
    logic [EW-1:0]    exp;
    logic [DW-1:0]    man_l;
    logic [DW-1:0]    man_s;
  } s1_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    spc_kind_e        spc;
    logic             spc_sign;
    logic             sign;
    logic             zero_sign;
    logic             is_zero;
    logic             unf;
    logic [XW-1:0]    exp;
    logic [DW-1:0]    man;
  } s2_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;

  logic             out_valid_d, out_valid_q;
  logic [W-1:0]     y_d, y_q;
  logic [TAG_W-1:0] out_tag_d, out_tag_q;
  logic             ovf_d, ovf_q;
  logic             unf_d, unf_q;

  logic en;
  assign en = ~out_valid_q | out_ready;

  // ---------------- S1: unpack, order by magnitude, align ----------------
  fp_word_t      a_w, b_w;
  logic          sa, sb, a_big, nan_any, inf_a, inf_b;
  logic [EW-1:0] ea, eb, e_l, e_s, e_diff;
  logic [MW-1:0] ma, mb;
  logic [DW-1:0] sig_l, sig_s, sig_s_shr, sig_s_lost;

  always_comb begin
    a_w    = fp_word_t'(x1);
    b_w    = fp_word_t'(x2);
    sa     = fp_sign(a_w, EW, MW);
    sb     = fp_sign(b_w, EW, MW) ^ sub;
    ea     = EW'(fp_exp(a_w, EW, MW));
    eb     = EW'(fp_exp(b_w, EW, MW));
    ma     = fp_is_zero(a_w, EW, MW) ? '0 : MW'(fp_man(a_w, MW));
    mb     = fp_is_zero(b_w, EW, MW) ? '0 : MW'(fp_man(b_w, MW));
    a_big  = {ea, ma} >= {eb, mb};
    e_l    = a_big ? ea : eb;
    e_s    = a_big ? eb : ea;
    sig_l  = {(e_l != '0), (a_big ? ma : mb), 3'b000};
    sig_s  = {(e_s != '0), (a_big ? mb : ma), 3'b000};
    e_diff = e_l - e_s;
    // Oversized shifts give shr = 0 and lost = everything, leaving only sticky.
    sig_s_shr  = sig_s >> e_diff;
    sig_s_lost = sig_s & ~({DW{1'b1}} << e_diff);
    nan_any    = fp_is_nan(a_w, EW, MW) | fp_is_nan(b_w, EW, MW);
    inf_a      = fp_is_inf(a_w, EW, MW);
    inf_b      = fp_is_inf(b_w, EW, MW);

    s1_d           = '0;
    s1_d.valid     = in_valid;
    s1_d.tag       = in_tag;
    s1_d.sign      = a_big ? sa : sb;
    s1_d.zero_sign = sa & sb;
    s1_d.eff_sub   = sa ^ sb;
    s1_d.exp       = e_l;
    s1_d.man_l     = sig_l;
    s1_d.man_s     = sig_s_shr | DW'(|sig_s_lost);
    s1_d.spc       = SPC_NONE;
    if (nan_any || (inf_a && inf_b && (sa != sb))) begin
      s1_d.spc = SPC_QNAN;
    end else if (inf_a) begin
      s1_d.spc      = SPC_INF;
      s1_d.spc_sign = sa;
    end else if (inf_b) begin
      s1_d.spc      = SPC_INF;
      s1_d.spc_sign = sb;
    end
  end

  // ---------------- S2: add/subtract, normalise ----------------
  logic [DW:0]   sum;
  logic [CW-1:0] lz;
  logic          sum_zero;

  fp_lzc #(.N(LZW), .CW(CW)) u_lzc (
    .din (sum[DW-1:2]),
    .cnt (lz)
  );

  always_comb begin
    sum      = s1_q.eff_sub ? ({1'b0, s1_q.man_l} - {1'b0, s1_q.man_s})
                            : ({1'b0, s1_q.man_l} + {1'b0, s1_q.man_s});
    sum_zero = (sum == '0);

    s2_d           = '0;
    s2_d.valid     = s1_q.valid;
    s2_d.tag       = s1_q.tag;
    s2_d.spc       = s1_q.spc;
    s2_d.spc_sign  = s1_q.spc_sign;
    s2_d.sign      = s1_q.sign;
    s2_d.zero_sign = s1_q.zero_sign;
    s2_d.is_zero   = sum_zero;
    if (sum[DW]) begin
      s2_d.man = {sum[DW:2], |sum[1:0]};
      s2_d.exp = {1'b0, s1_q.exp} + XW'(1);
    end else begin
      s2_d.man = sum[DW-1:0] << lz;
      s2_d.exp = {1'b0, s1_q.exp} - XW'(lz);
      s2_d.unf = !sum_zero && ({1'b0, s1_q.exp} <= XW'(lz));
    end
  end

  // ---------------- S3: round, exponent adjust, specials ----------------
  logic          round_up;
  logic [RW-1:0] mant_r;
  logic [XW-1:0] exp_r;
  logic [MW-1:0] frac;

  always_comb begin
    round_up = s2_q.man[2] & (s2_q.man[1] | s2_q.man[0] | s2_q.man[3]);
    mant_r   = {1'b0, s2_q.man[DW-1:3]} + RW'(round_up);
    exp_r    = s2_q.exp + XW'(mant_r[MW+1]);
    frac     = mant_r[MW+1] ? mant_r[MW:1] : mant_r[MW-1:0];

    out_valid_d = s2_q.valid;
    out_tag_d   = s2_q.tag;
    ovf_d       = 1'b0;
    unf_d       = 1'b0;
    if (s2_q.spc == SPC_QNAN) begin
      y_d = W'(fp_qnan(EW, MW));
    end else if (s2_q.spc == SPC_INF) begin
      y_d = {s2_q.spc_sign, EXP_ONES, {MW{1'b0}}};
    end else if (s2_q.is_zero) begin
      y_d = {s2_q.zero_sign, {(W-1){1'b0}}};
    end else if (s2_q.unf) begin
      y_d   = {s2_q.sign, {(W-1){1'b0}}};
      unf_d = 1'b1;
    end else if (exp_r >= {1'b0, EXP_ONES}) begin
      y_d   = {s2_q.sign, EXP_ONES, {MW{1'b0}}};
      ovf_d = 1'b1;
    end else begin
      y_d = {s2_q.sign, exp_r[EW-1:0], frac};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q        <= '0;
      s2_q        <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      out_tag_q   <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else if (en) begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      out_tag_q   <= out_tag_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign out_tag   = out_tag_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe (binary32): arithmetic vectors, specials,
// backpressure ordering/stability and mid-stream reset.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1, x2;
  logic        sub;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic [4:0]  out_tag;
  logic        ovf, unf;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  fp_addsub_pipe #(.EW(8), .MW(23), .TAG_W(5)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .sub       (sub),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .out_tag   (out_tag),
    .ovf       (ovf),
    .unf       (unf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One operation with out_ready held high; checks latency and all outputs.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [4:0] tg, input logic [31:0] ey,
                        input logic eo, input logic eu);
    int  lat;
    bit  got;
    @(negedge clk);
    x1 = a; x2 = b; sub = s; in_tag = tg; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("op_in_ready", in_ready, 1);
    lat = 0;
    got = 0;
    while (lat < 10 && !got) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      #1;
      if (out_valid) got = 1;
    end
    chk("op_latency", lat, 3);
    chk("op_y", y, ey);
    chk("op_tag", out_tag, tg);
    chk("op_ovf", ovf, eo);
    chk("op_unf", unf, eu);
    $display("op %h %s %h tag=%0d -> y=%h ovf=%0b unf=%0b lat=%0d",
             a, s ? "-" : "+", b, tg, y, ovf, unf, lat);
  endtask

  logic [31:0] bp_x2  [6];
  logic [31:0] bp_exp [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          issue, recv;
    bit          prev_stall;
    logic [31:0] prev_y;
    logic [4:0]  prev_tag;

    rstn = 1'b0; in_valid = 1'b0; x1 = '0; x2 = '0; sub = 1'b0; in_tag = '0; out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Directed arithmetic and special-case vectors
    run_op(32'h3F800000, 32'h40000000, 1'b0, 5'd7,  32'h40400000, 1'b0, 1'b0);
    run_op(32'h3F800000, 32'h3F800000, 1'b1, 5'd1,  32'h00000000, 1'b0, 1'b0);
    run_op(32'h80000000, 32'h80000000, 1'b0, 5'd2,  32'h80000000, 1'b0, 1'b0);
    run_op(32'h00000000, 32'h80000000, 1'b0, 5'd3,  32'h00000000, 1'b0, 1'b0);
    run_op(32'h3F800000, 32'h33800000, 1'b0, 5'd4,  32'h3F800000, 1'b0, 1'b0);
    run_op(32'h3F800001, 32'h33800000, 1'b0, 5'd5,  32'h3F800002, 1'b0, 1'b0);
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 5'd6,  32'h7F800000, 1'b1, 1'b0);
    run_op(32'h00800001, 32'h00800000, 1'b1, 5'd8,  32'h00000000, 1'b0, 1'b1);
    run_op(32'h7F800000, 32'h7F800000, 1'b1, 5'd9,  32'h7FC00000, 1'b0, 1'b0);
    run_op(32'h7FA00000, 32'h3F800000, 1'b0, 5'd10, 32'h7FC00000, 1'b0, 1'b0);
    run_op(32'hFF800000, 32'h3F800000, 1'b0, 5'd11, 32'hFF800000, 1'b0, 1'b0);
    run_op(32'h40400000, 32'h3F800000, 1'b1, 5'd12, 32'h40000000, 1'b0, 1'b0);
    run_op(32'h3F800000, 32'hBF800000, 1'b0, 5'd13, 32'h00000000, 1'b0, 1'b0);
    run_op(32'h7F800000, 32'hFF800000, 1'b1, 5'd14, 32'h7F800000, 1'b0, 1'b0);
    run_op(32'h3F800000, 32'h40000000, 1'b1, 5'd15, 32'hBF800000, 1'b0, 1'b0);
    run_op(32'h00400000, 32'h3F800000, 1'b0, 5'd16, 32'h3F800000, 1'b0, 1'b0);
    run_op(32'h3F800000, 32'h33800000, 1'b1, 5'd17, 32'h3F7FFFFF, 1'b0, 1'b0);

    // Backpressure: 1.0 + k for k = 1..6, stall consumer in cycles 3..8
    bp_x2[0] = 32'h3F800000; bp_exp[0] = 32'h40000000;
    bp_x2[1] = 32'h40000000; bp_exp[1] = 32'h40400000;
    bp_x2[2] = 32'h40400000; bp_exp[2] = 32'h40800000;
    bp_x2[3] = 32'h40800000; bp_exp[3] = 32'h40A00000;
    bp_x2[4] = 32'h40A00000; bp_exp[4] = 32'h40C00000;
    bp_x2[5] = 32'h40C00000; bp_exp[5] = 32'h40E00000;
    issue = 0; recv = 0; prev_stall = 0; prev_y = '0; prev_tag = '0;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 8);
      if (issue < 6) begin
        in_valid = 1'b1; x1 = 32'h3F800000; x2 = bp_x2[issue]; sub = 1'b0;
        in_tag = 5'(issue);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        chk("bp_in_ready_stall", in_ready, 0);
        if (prev_stall) begin
          chk("bp_y_hold", y, prev_y);
          chk("bp_tag_hold", out_tag, prev_tag);
        end
        prev_stall = 1; prev_y = y; prev_tag = out_tag;
      end else begin
        prev_stall = 0;
      end
      if (out_valid && out_ready) begin
        chk("bp_tag_order", out_tag, recv);
        chk("bp_y", y, bp_exp[recv]);
        $display("bp cycle=%0d tag=%0d y=%h", c, out_tag, y);
        recv++;
      end
      if (in_valid && in_ready) issue++;
    end
    chk("bp_count", recv, 6);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("bp_no_dup", out_valid, 0);
    end

    // Mid-stream reset: three ops in flight, reset when the first emerges
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; x1 = 32'h3F800000; x2 = bp_x2[k]; sub = 1'b0; in_tag = 5'(20 + k);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("mr_first_valid", out_valid, 1);
    chk("mr_first_tag", out_tag, 20);
    rstn = 1'b0;
    @(negedge clk);
    #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_y", y, 0);
    chk("mr_in_ready", in_ready, 1);
    rstn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("mr_no_stale", out_valid, 0);
    end
    $display("reset mid-stream done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
